// File: rtl/pwm_scan_ctrl.sv
// LED-matrix scan controller: shifts one row of pixel data per pass and latches it.
// It then lights the row while a PWM threshold sweeps 0..pwm_top once per row.
module pwm_scan_ctrl #(
  parameter int unsigned PWM_WIDTH   = 12,
  parameter int unsigned COL_BITS    = 5,
  parameter int unsigned ROW_BITS    = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [PWM_WIDTH-1:0] pwm_top,
  output logic [PWM_WIDTH-1:0] pwmlvl,
  output logic [COL_BITS-1:0]  col,
  output logic [ROW_BITS-1:0]  row,
  output logic [ROW_BITS-1:0]  row_addr,
  output logic                 sclk,
  output logic                 latch,
  output logic                 blank,
  output logic                 frame_start
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_FLUSH,
    S_LATCH,
    S_DISPLAY
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [PWM_WIDTH-1:0] pwm_top_reg;

  logic at_frame_origin;
  logic start_pass;
  logic pass_done;
  logic blank_d;
  logic latch_d;
  logic sclk_d;
  logic frame_start_d;

  assign at_frame_origin = (row == '0) && (pwmlvl == '0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; enable only matters in IDLE so a started pass always completes
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (enable) next_state = S_SHIFT;
      S_SHIFT:   if (col == '1) next_state = S_FLUSH;
      S_FLUSH:   next_state = S_LATCH;
      S_LATCH:   next_state = S_DISPLAY;
      S_DISPLAY: if (hold_cnt == HOLD_LAST) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Output decode: values the output registers take on the coming edge
  always_comb begin
    start_pass    = 1'b0;
    pass_done     = 1'b0;
    blank_d       = 1'b1;
    latch_d       = 1'b0;
    sclk_d        = 1'b0;
    frame_start_d = 1'b0;
    if (state == S_IDLE && next_state == S_SHIFT) start_pass = 1'b1;
    if (state == S_DISPLAY && next_state == S_IDLE) pass_done = 1'b1;
    case (next_state)
      S_DISPLAY: blank_d = 1'b0;
      S_LATCH:   latch_d = 1'b1;
      default:   ;
    endcase
    // sclk trails column validity by one stage so the last column is clocked in FLUSH
    sclk_d        = (state == S_SHIFT);
    frame_start_d = start_pass && at_frame_origin;
  end

  // Registered strobes
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk        <= 1'b0;
      latch       <= 1'b0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      sclk        <= sclk_d;
      latch       <= latch_d;
      blank       <= blank_d;
      frame_start <= frame_start_d;
    end
  end

  // Column / hold counters, row and PWM sweep; pwmlvl and row only move at pass end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col         <= '0;
      hold_cnt    <= '0;
      pwmlvl      <= '0;
      row         <= '0;
      row_addr    <= '0;
      pwm_top_reg <= '0;
    end else begin
      col      <= (state == S_SHIFT) ? col + COL_BITS'(1) : '0;
      hold_cnt <= (state == S_DISPLAY) ? hold_cnt + HOLD_W'(1) : '0;
      if (start_pass && at_frame_origin) pwm_top_reg <= pwm_top;
      if (state == S_LATCH) row_addr <= row;
      if (pass_done) begin
        if (pwmlvl == pwm_top_reg) begin
          pwmlvl <= '0;
          row    <= row + ROW_BITS'(1);
        end else begin
          pwmlvl <= pwmlvl + PWM_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_scan_ctrl.sv
// Bench for pwm_scan_ctrl: a pass-position model checked every cycle,
// plus directed scenarios with literal expected sequences.
module tb_pwm_scan_ctrl;

  localparam int PW    = 4;
  localparam int CB    = 2;
  localparam int RB    = 1;
  localparam int HOLD  = 2;
  localparam int COLS  = 1 << CB;
  localparam int ROWS  = 1 << RB;
  localparam int PASS  = COLS + HOLD + 3;

  localparam int LV_A[7]  = '{0, 1, 2, 0, 1, 2, 0};
  localparam int RW_A[7]  = '{0, 0, 0, 1, 1, 1, 0};
  localparam int LV_B[12] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 4, 5};
  localparam int RW_B[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  localparam int RW_E[4]  = '{0, 1, 0, 1};

  logic          clk;
  logic          resetn;
  logic          enable;
  logic [PW-1:0] pwm_top;
  logic [PW-1:0] pwmlvl;
  logic [CB-1:0] col;
  logic [RB-1:0] row;
  logic [RB-1:0] row_addr;
  logic          sclk;
  logic          latch;
  logic          blank;
  logic          frame_start;

  int n_checks = 0;
  int n_errors = 0;

  pwm_scan_ctrl #(
    .PWM_WIDTH(PW), .COL_BITS(CB), .ROW_BITS(RB), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .pwm_top(pwm_top),
    .pwmlvl(pwmlvl), .col(col), .row(row), .row_addr(row_addr),
    .sclk(sclk), .latch(latch), .blank(blank), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: k = position within a pass (0 idle, 1..COLS shift, then flush, latch, hold)
  int k = 0;
  int m_lvl = 0;
  int m_row = 0;
  int m_top = 0;
  int m_raddr = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      k <= 0; m_lvl <= 0; m_row <= 0; m_top <= 0; m_raddr <= 0;
      model_valid <= 1'b1;
    end else if (k == 0) begin
      if (enable) begin
        k <= 1;
        if (m_row == 0 && m_lvl == 0) m_top <= int'(pwm_top);
      end
    end else if (k == PASS - 1) begin
      k <= 0;
      if (m_lvl == m_top) begin
        m_lvl <= 0;
        m_row <= (m_row + 1) % ROWS;
      end else begin
        m_lvl <= m_lvl + 1;
      end
    end else begin
      k <= k + 1;
      if (k == COLS + 2) m_raddr <= m_row;
    end
  end

  // Event recorder, cleared by reset; cycle 1 is the first cycle after reset release
  int cyc = 0;
  int sclk_cnt = 0;
  int fs_cyc[$];
  int lat_cyc[$];
  int lat_lvl[$];
  int lat_row[$];

  always @(negedge clk) begin
    if (!resetn) begin
      cyc <= 0;
      sclk_cnt <= 0;
      fs_cyc.delete();
      lat_cyc.delete();
      lat_lvl.delete();
      lat_row.delete();
    end else begin
      cyc <= cyc + 1;
      if (sclk) sclk_cnt <= sclk_cnt + 1;
      if (frame_start) fs_cyc.push_back(cyc + 1);
      if (latch) begin
        lat_cyc.push_back(cyc + 1);
        lat_lvl.push_back(int'(pwmlvl));
        lat_row.push_back(int'(row));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    if (!model_valid) return;
    chk("m_blank", int'(blank), (k >= COLS + 3) ? 0 : 1);
    chk("m_col", int'(col), (k >= 1 && k <= COLS) ? k - 1 : 0);
    chk("m_sclk", int'(sclk), (k >= 2 && k <= COLS + 1) ? 1 : 0);
    chk("m_latch", int'(latch), (k == COLS + 2) ? 1 : 0);
    chk("m_frame_start", int'(frame_start), (k == 1 && m_row == 0 && m_lvl == 0) ? 1 : 0);
    chk("m_pwmlvl", int'(pwmlvl), m_lvl);
    chk("m_row", int'(row), m_row);
    chk("m_row_addr", int'(row_addr), m_raddr);
  endtask

  // Advance n cycles, comparing against the model mid-cycle; returns just after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wait_cyc(2);
    resetn = 1'b1;
  endtask

  initial begin
    resetn  = 1'b0;
    enable  = 1'b0;
    pwm_top = '0;

    // Basic sweep with top=2, seven passes
    do_reset();
    chk("rst_blank", int'(blank), 1);
    chk("rst_pwmlvl", int'(pwmlvl), 0);
    chk("rst_sclk", int'(sclk), 0);
    enable = 1'b1; pwm_top = PW'(2);
    wait_cyc(63);
    chk("A_fs_n", fs_cyc.size(), 2);
    chk("A_fs0", (fs_cyc.size() > 0) ? fs_cyc[0] : -1, 2);
    chk("A_fs1", (fs_cyc.size() > 1) ? fs_cyc[1] : -1, 56);
    chk("A_lat_n", lat_cyc.size(), 7);
    chk("A_lat0", (lat_cyc.size() > 0) ? lat_cyc[0] : -1, 7);
    chk("A_lat1", (lat_cyc.size() > 1) ? lat_cyc[1] : -1, 16);
    chk("A_sclk_cnt", sclk_cnt, 28);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("A_lvl%0d", i), (i < lat_lvl.size()) ? lat_lvl[i] : -1, LV_A[i]);
      chk($sformatf("A_row%0d", i), (i < lat_row.size()) ? lat_row[i] : -1, RW_A[i]);
    end

    // pwm_top changed mid-frame only takes effect at the next frame start
    do_reset();
    enable = 1'b1; pwm_top = PW'(2);
    wait_cyc(11);
    pwm_top = PW'(5);
    wait_cyc(97);
    chk("B_lat_n", lat_lvl.size(), 12);
    chk("B_fs1", (fs_cyc.size() > 1) ? fs_cyc[1] : -1, 56);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("B_lvl%0d", i), (i < lat_lvl.size()) ? lat_lvl[i] : -1, LV_B[i]);
      chk($sformatf("B_row%0d", i), (i < lat_row.size()) ? lat_row[i] : -1, RW_B[i]);
    end

    // enable dropped during SHIFT: pass finishes, then parks dark
    do_reset();
    enable = 1'b1; pwm_top = PW'(2);
    wait_cyc(2);
    enable = 1'b0;
    wait_cyc(18);
    chk("C_lat_n", lat_cyc.size(), 1);
    chk("C_lat0", (lat_cyc.size() > 0) ? lat_cyc[0] : -1, 7);
    chk("C_sclk_cnt", sclk_cnt, 4);
    chk("C_fs_n", fs_cyc.size(), 1);
    chk("C_blank", int'(blank), 1);
    chk("C_pwmlvl", int'(pwmlvl), 1);
    chk("C_row", int'(row), 0);

    // One-cycle reset during DISPLAY
    do_reset();
    enable = 1'b1; pwm_top = PW'(2);
    wait_cyc(7);
    chk("D_pre_lat_n", lat_cyc.size(), 1);
    chk("D_pre_blank", int'(blank), 0);
    resetn = 1'b0;
    wait_cyc(1);
    resetn = 1'b1;
    chk("D_blank", int'(blank), 1);
    chk("D_latch", int'(latch), 0);
    chk("D_pwmlvl", int'(pwmlvl), 0);
    chk("D_row", int'(row), 0);
    chk("D_col", int'(col), 0);
    chk("D_sclk", int'(sclk), 0);
    wait_cyc(20);
    chk("D_fs_n", fs_cyc.size(), 1);
    chk("D_fs0", (fs_cyc.size() > 0) ? fs_cyc[0] : -1, 2);
    chk("D_lat0", (lat_cyc.size() > 0) ? lat_cyc[0] : -1, 7);

    // pwm_top = 0: every pass advances the row
    do_reset();
    enable = 1'b1; pwm_top = PW'(0);
    wait_cyc(36);
    chk("E_lat_n", lat_row.size(), 4);
    chk("E_fs_n", fs_cyc.size(), 2);
    chk("E_fs1", (fs_cyc.size() > 1) ? fs_cyc[1] : -1, 20);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("E_row%0d", i), (i < lat_row.size()) ? lat_row[i] : -1, RW_E[i]);
      chk($sformatf("E_lvl%0d", i), (i < lat_lvl.size()) ? lat_lvl[i] : -1, 0);
    end

    // pwm_top all ones: full 0..15 sweep without overflow
    do_reset();
    enable = 1'b1; pwm_top = PW'(15);
    wait_cyc(153);
    chk("F_lat_n", lat_lvl.size(), 17);
    chk("F_lvl15", (lat_lvl.size() > 15) ? lat_lvl[15] : -1, 15);
    chk("F_row15", (lat_row.size() > 15) ? lat_row[15] : -1, 0);
    chk("F_lvl16", (lat_lvl.size() > 16) ? lat_lvl[16] : -1, 0);
    chk("F_row16", (lat_row.size() > 16) ? lat_row[16] : -1, 1);
    chk("F_fs_n", fs_cyc.size(), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
